// File: rtl/uart_tx_pkg.sv
// Shared definitions for the 8N1 UART transmitter: state encoding,
// default bit period and a counter-width helper.
`timescale 1ns/1ps

package uart_tx_pkg;

  // 12 MHz system clock / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;

  // Data bits per frame (8N1)
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Width of the bit-period counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Reloadable bit-period down-counter. tick is high on the last cycle of
// each bit period while enabled; clear restarts a full period.
`timescale 1ns/1ps

module baud_tick
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt = '0;

  // Count down from RELOAD to zero, reloading at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= RELOAD;
    end else if (enable) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - W'(1);
    end
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A one-cycle transmit request in IDLE latches
// tx_byte and sends start bit, 8 data bits LSB first, then stop bit, each
// held for CLKS_PER_BIT cycles. Requests while busy are dropped.
// All outputs come straight from flops.
`timescale 1ns/1ps

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       is_transmitting,
  output logic       tx,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state = IDLE;
  state_t     state_next;
  logic [7:0] shift = '0;
  logic [7:0] shift_next;
  logic [2:0] bit_idx = '0;
  logic [2:0] bit_idx_next;
  logic       tx_q = 1'b1;
  logic       tx_next;
  logic       busy_q = 1'b0;
  logic       busy_next;
  logic       done_q = 1'b0;
  logic       done_next;
  logic       accept;
  logic       tick;

  assign accept = (state == IDLE) && transmit;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state != IDLE),
    .tick  (tick)
  );

  // Next-state and next-output logic; outputs hold unless a bit boundary hits.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    tx_next      = tx_q;
    busy_next    = busy_q;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (transmit) begin
          state_next   = START;
          shift_next   = tx_byte;
          bit_idx_next = '0;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          tx_next      = shift[0];
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      tx_q    <= tx_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
    end
  end

  assign tx              = tx_q;
  assign is_transmitting = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4. Expected line levels
// come from the 8N1 frame definition; an echo loop feeds a line decoder.
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       is_transmitting;
  logic       tx;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  logic       rx_en = 1'b0;
  logic [7:0] rx_q[$];
  logic       halted = 1'b0;
  int         halt_pulses = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_byte        (tx_byte),
    .transmit       (transmit),
    .is_transmitting(is_transmitting),
    .tx             (tx),
    .tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge halted) halt_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level of bit k (0..9) of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, " idle tx"}, 32'(tx), 32'd1);
      chk({tag, " idle busy"}, 32'(is_transmitting), 32'd0);
      chk({tag, " idle done"}, 32'(tx_done), 32'd0);
    end
  endtask

  // Send b, check every cycle of the frame; optionally pulse a second
  // request (late_byte) during frame cycle late_cycle+1.
  task automatic run_frame(input string tag, input logic [7:0] b,
                           input int late_cycle, input logic [7:0] late_byte);
    logic exp_q[$];
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < CPB; j++) exp_q.push_back(frame_bit(b, k));
    tx_byte  = b;
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    for (int c = 0; c < 10 * CPB; c++) begin
      chk($sformatf("%s tx c%0d", tag, c + 1), 32'(tx), 32'(exp_q[c]));
      chk($sformatf("%s busy c%0d", tag, c + 1), 32'(is_transmitting), 32'd1);
      chk($sformatf("%s done c%0d", tag, c + 1), 32'(tx_done), 32'd0);
      tx_byte  = 8'($urandom);
      transmit = (c == late_cycle);
      if (c == late_cycle) tx_byte = late_byte;
      tick();
    end
    transmit = 1'b0;
    chk({tag, " end tx"}, 32'(tx), 32'd1);
    chk({tag, " end busy"}, 32'(is_transmitting), 32'd0);
    chk({tag, " end done"}, 32'(tx_done), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input logic want, input int limit);
    int n = 0;
    while (is_transmitting !== want && n < limit) begin
      tick();
      n++;
    end
    chk({tag, " wait busy"}, 32'(is_transmitting), 32'(want));
  endtask

  // Line decoder: samples mid-bit on falling clock edges.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx;
          end
          repeat (CPB) @(negedge clk);
          if (tx === 1'b1) rx_q.push_back(d);
        end
      end
    end
  end

  initial begin
    logic [7:0] mem[3];
    logic [7:0] b;
    logic [7:0] rb;
    int pc;
    int late;

    // Power-up values before any clock edge
    #1;
    chk("powerup tx", 32'(tx), 32'd1);
    chk("powerup busy", 32'(is_transmitting), 32'd0);
    chk("powerup done", 32'(tx_done), 32'd0);

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(is_transmitting), 32'd0);
    chk("reset done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    idle_check("post reset", 100);

    // Single frame 0x55
    run_frame("f55", 8'h55, -1, 8'h00);
    idle_check("after f55", 5);

    // Back-to-back 0x00 then 0xFF
    run_frame("f00", 8'h00, -1, 8'h00);
    run_frame("fFF", 8'hFF, -1, 8'h00);
    idle_check("after fFF", 5);

    // Request while busy is dropped
    run_frame("f3C", 8'h3C, 9, 8'hA3);
    idle_check("no A3", 20);

    // Reset at cycle 17 of a frame
    tx_byte  = 8'h96;
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("abort tx c%0d", c + 1), 32'(tx), 32'(frame_bit(8'h96, c / CPB)));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort tx", 32'(tx), 32'd1);
    chk("abort busy", 32'(is_transmitting), 32'd0);
    chk("abort done", 32'(tx_done), 32'd0);
    idle_check("abort", 3 * 10 * CPB);
    run_frame("after abort", 8'($urandom), -1, 8'h00);
    idle_check("after abort", 2);

    // transmit together with rst
    rst      = 1'b1;
    transmit = 1'b1;
    tx_byte  = 8'h5A;
    tick();
    rst      = 1'b0;
    transmit = 1'b0;
    chk("rst+tx tx", 32'(tx), 32'd1);
    chk("rst+tx busy", 32'(is_transmitting), 32'd0);
    idle_check("rst+tx", 100);

    // Randomized frames with random gaps and random dropped requests
    for (int f = 0; f < 6; f++) begin
      b    = 8'($urandom);
      rb   = 8'($urandom);
      late = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10 * CPB - 1)) : -1;
      run_frame($sformatf("rnd%0d", f), b, late, rb);
      idle_check($sformatf("rnd%0d gap", f), int'($urandom_range(0, 3)));
    end

    // CPU echo loop from a small RAM holding "Hi",0
    mem[0] = 8'h48;
    mem[1] = 8'h69;
    mem[2] = 8'h00;
    rx_q.delete();
    rx_en = 1'b1;
    pc    = 0;
    for (int step = 0; step < 8; step++) begin
      b = mem[pc];
      if (b == 8'h00) begin
        halted = 1'b1;
        tick();
        halted = 1'b0;
        break;
      end
      wait_busy("echo idle", 1'b0, 20 * CPB);
      tx_byte  = b;
      transmit = 1'b1;
      tick();
      transmit = 1'b0;
      chk("echo accept", 32'(is_transmitting), 32'd1);
      pc++;
    end
    wait_busy("echo drain", 1'b0, 20 * CPB);
    repeat (4 * CPB) tick();
    rx_en = 1'b0;
    chk("echo rx count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 2) begin
      chk("echo rx0", 32'(rx_q[0]), 32'h48);
      chk("echo rx1", 32'(rx_q[1]), 32'h69);
    end
    chk("echo halted pulses", 32'(halt_pulses), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clock cycles per serial bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tx_byte  input  8  byte to send; sampled only on the accept cycle.
REQ-005 transmit  input  1  one-cycle send request from the CPU.
REQ-006 is_transmitting  output  1  busy flag, registered.
REQ-007 tx  output  1  serial line, idle high, registered.
REQ-008 tx_done  output  1  one-cycle pulse at frame end, registered.

Function
REQ-009 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-010 State machine SHALL have states IDLE, START, DATA, STOP.
REQ-011 Accept rule: a request is accepted on a rising edge where the FSM is in IDLE, transmit=1 and rst=0; tx_byte is latched into a shift register on that edge.
REQ-012 transmit while not in IDLE SHALL be ignored: no queuing, no frame corruption, no change to the latched byte.
REQ-013 On the accept edge: state<=START, is_transmitting<=1 and tx<=0, so both are visible in the cycle after transmit.
REQ-014 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles; a bit counter of width clog2(CLKS_PER_BIT) reloads at every bit boundary.
REQ-015 START->DATA after CLKS_PER_BIT cycles; tx<=shift[0].
REQ-016 DATA: at each bit boundary, shift right and drive the next bit; after the 8th data bit, DATA->STOP with tx<=1; a 3-bit index counts bits 0..7.
REQ-017 STOP->IDLE after CLKS_PER_BIT cycles; on that edge is_transmitting<=0 and tx_done<=1 for exactly one cycle.
REQ-018 is_transmitting SHALL be high for exactly 10*CLKS_PER_BIT consecutive cycles per frame.
REQ-019 Back-to-back: a transmit arriving in the first cycle where is_transmitting=0 SHALL be accepted; the next start bit then begins with no extra idle bit beyond the stop bit.
REQ-020 tx SHALL be glitch-free: it changes only at bit boundaries and never toggles mid-bit.
REQ-021 tx_done and transmit in the same cycle: the new request is accepted only if the FSM is already in IDLE on that edge; tx_done itself does not block acceptance.

Reset
REQ-022 With rst=1 on an edge: state<=IDLE, tx<=1, is_transmitting<=0, tx_done<=0, and all counters and the shift register cleared.
REQ-023 Reset mid-frame SHALL abort the frame immediately, with tx high from the next cycle and no tx_done pulse.
REQ-024 transmit asserted together with rst SHALL be ignored.
REQ-025 Power-up register initial values SHALL equal the reset values.

Structure
REQ-026 A shared package SHALL hold the 2-bit state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT constant.
REQ-027 One sub-module, baud_tick, SHALL implement the reloadable bit-period counter (inputs: clear, enable; output: tick on the last cycle of a bit).
REQ-028 All outputs SHALL be driven directly from flops, with no combinational output paths.

Verification (CLKS_PER_BIT=4)
REQ-029 Send 0x55 with a one-cycle transmit -> tx reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy high 40 cycles; one tx_done pulse.
REQ-030 Send 0x00 then 0xFF, second transmit in the first non-busy cycle -> two contiguous 40-cycle frames; stop bit of the first directly followed by the start bit of the second.
REQ-031 transmit pulsed with 0xA3 at cycle 10 of a 0x3C frame -> 0x3C sent intact and 0xA3 never sent.
REQ-032 rst at cycle 17 of a frame -> tx=1 and is_transmitting=0 the next cycle, no tx_done, and the next request sends a clean frame.
REQ-033 transmit and rst high together -> no frame and tx stays 1; also check idle tx=1 for 100 cycles after reset.
REQ-034 CPU echo loop with a bench RAM holding "Hi",0x00 -> receiver model decodes 'H','i' and halted pulses once.
